// File: rtl/sub_rr_merge.sv
// sub_rr_merge: per-channel FIFOs drained round-robin into one registered, channel-tagged valid/ready output.
// Optional packet lock when SUB_RR_MERGE_PKT_LOCK_EN is defined.
module sub_rr_merge #(
  parameter int NCH = 4,
  parameter int DW = 32,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [CW-1:0]     out_ch,
  output logic              out_last,
  output logic              busy
);
  localparam int AW = $clog2(DEPTH);
  logic [DW:0] mem [NCH][DEPTH];
  logic [AW-1:0] wptr [NCH];
  logic [AW-1:0] rptr [NCH];
  logic [AW:0] cnt [NCH];
  logic [NCH-1:0] push, pop, nonempty, elig;
  logic [CW-1:0] last_grant, gnt;
  logic found, load;
  logic [DW:0] head;
`ifdef SUB_RR_MERGE_PKT_LOCK_EN
  logic locked;
  logic [CW-1:0] lock_ch;
`endif
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign in_ready[g] = cnt[g] != (AW+1)'(DEPTH);
    assign nonempty[g] = cnt[g] != '0;
    assign push[g] = in_valid[g] & in_ready[g];
    assign pop[g] = load && gnt == CW'(g);
`ifdef SUB_RR_MERGE_PKT_LOCK_EN
    assign elig[g] = nonempty[g] && (!locked || lock_ch == CW'(g));
`else
    assign elig[g] = nonempty[g];
`endif
  end
  // Search begins one past the last grant so the previous winner ranks last.
  always_comb begin
    gnt = '0;
    found = 1'b0;
    for (int i = 1; i <= NCH; i++)
      if (!found && elig[(int'(last_grant) + i) % NCH]) begin
        found = 1'b1;
        gnt = CW'((int'(last_grant) + i) % NCH);
      end
  end
  assign load = (!out_valid || out_ready) && found;
  assign head = mem[gnt][rptr[gnt]];
  assign busy = out_valid || (|nonempty);
  always_ff @(posedge clk)
    for (int c = 0; c < NCH; c++)
      if (push[c] && !rst) mem[c][wptr[c]] <= {in_last[c], in_data[c*DW +: DW]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
        cnt[c] <= '0;
      end
      last_grant <= CW'(NCH - 1);
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      out_last <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (push[c]) wptr[c] <= wptr[c] + 1'b1;
        if (pop[c]) rptr[c] <= rptr[c] + 1'b1;
        cnt[c] <= cnt[c] + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
      end
      if (load) begin
        out_valid <= 1'b1;
        out_data <= head[DW-1:0];
        out_last <= head[DW];
        out_ch <= gnt;
        last_grant <= gnt;
      end else if (out_ready) out_valid <= 1'b0;
    end
`ifdef SUB_RR_MERGE_PKT_LOCK_EN
  // A popped non-last beat pins the arbiter to its channel until that packet's last beat leaves.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      locked <= 1'b0;
      lock_ch <= '0;
    end else if (load) begin
      locked <= !head[DW];
      lock_ch <= gnt;
    end
`endif
endmodule
